// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rptr_empty_ctrl
// Purpose  : Read-side pointer, empty/almost-empty, fill level and underflow
//            flag generation for a dual-clock asynchronous FIFO.
// Revision : 1.0  initial release
// ============================================================================
module rptr_empty_ctrl #(
  parameter int ADDR_SIZE     = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic                 rclr_err,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rpop,
  output logic                 rempty,
  output logic                 raempty,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 rerr_uf
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] c_DEPTH     = PW'(1) << ADDR_SIZE;
  localparam logic [PW-1:0] c_AE_THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] rbin_q,    rbin_d;
  logic [PW-1:0] rptr_q,    rptr_d;
  logic [PW-1:0] rlevel_q,  rlevel_d;
  logic          rempty_q,  rempty_d;
  logic          raempty_q, raempty_d;
  logic          rerr_uf_q, rerr_uf_d;

  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_diff;
  logic          w_pop;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
    assign w_wbin[gi] = ^rq2_wptr[PW-1:gi];
  end

  assign w_pop = rinc & ~rempty_q;

  always_comb begin
    rbin_d    = rbin_q + {{ADDR_SIZE{1'b0}}, w_pop};
    rptr_d    = (rbin_d >> 1) ^ rbin_d;
    w_diff    = w_wbin - rbin_d;
    rlevel_d  = (w_diff > c_DEPTH) ? c_DEPTH : w_diff;
    rempty_d  = (rptr_d == rq2_wptr);
    raempty_d = (rlevel_d <= c_AE_THRESH);
    // An underflow in the same cycle as a clear keeps the flag set.
    if (rinc && rempty_q) begin
      rerr_uf_d = 1'b1;
    end else if (rclr_err) begin
      rerr_uf_d = 1'b0;
    end else begin
      rerr_uf_d = rerr_uf_q;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rerr_uf_q <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      rerr_uf_q <= rerr_uf_d;
    end
  end

  assign raddr   = rbin_q[ADDR_SIZE-1:0];
  assign rptr    = rptr_q;
  assign rpop    = w_pop;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;
  assign rerr_uf = rerr_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rptr_empty_ctrl
// Purpose  : Directed scoreboard bench for rptr_empty_ctrl (ADDR_SIZE=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_rptr_empty_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic       rclr_err;
  logic [3:0] rq2_wptr;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rpop;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       rerr_uf;

  always #5 rclk = ~rclk;

  rptr_empty_ctrl #(.ADDR_SIZE(3), .AEMPTY_THRESH(2)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rinc     (rinc),
    .rclr_err (rclr_err),
    .rq2_wptr (rq2_wptr),
    .raddr    (raddr),
    .rptr     (rptr),
    .rpop     (rpop),
    .rempty   (rempty),
    .raempty  (raempty),
    .rlevel   (rlevel),
    .rerr_uf  (rerr_uf)
  );

  typedef struct {
    logic       pop;
    logic       empty;
    logic       aempty;
    logic [3:0] lvl;
    logic [3:0] ptr;
    logic [2:0] addr;
    logic       uf;
    bit         onebit;
    bit         chk_pre;
    logic [3:0] pre_lvl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [3:0] g(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  function automatic exp_t mk(input logic p, input logic em, input logic ae,
                              input logic [3:0] l, input logic [3:0] pt,
                              input logic [2:0] a, input logic u);
    exp_t e;
    e.pop = p; e.empty = em; e.aempty = ae; e.lvl = l; e.ptr = pt;
    e.addr = a; e.uf = u; e.onebit = 1'b0; e.chk_pre = 1'b0; e.pre_lvl = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic ri, input logic rc,
                      input logic [3:0] w, input exp_t e);
    @(negedge rclk);
    rrst_n   = rn;
    rinc     = ri;
    rclr_err = rc;
    rq2_wptr = w;
    q.push_back(e);
  endtask

  // Monitor: pre-edge checks just before the rising edge, registered checks after it.
  initial begin
    exp_t       it;
    logic [3:0] prev_ptr;
    prev_ptr = '0;
    forever begin
      @(negedge rclk);
      #4;
      if (q.size() > 0) begin
        it = q.pop_front();
        if (it.pop !== 1'bx) chk("rpop", {7'd0, rpop}, {7'd0, it.pop});
        if (it.chk_pre) begin
          chk("pre_edge_rlevel", {4'd0, rlevel}, {4'd0, it.pre_lvl});
          chk("pre_edge_rempty", {7'd0, rempty}, 8'd0);
        end
        prev_ptr = rptr;
        @(posedge rclk);
        #1;
        chk("rempty",  {7'd0, rempty},  {7'd0, it.empty});
        chk("raempty", {7'd0, raempty}, {7'd0, it.aempty});
        chk("rlevel",  {4'd0, rlevel},  {4'd0, it.lvl});
        chk("rptr",    {4'd0, rptr},    {4'd0, it.ptr});
        chk("raddr",   {5'd0, raddr},   {5'd0, it.addr});
        chk("rerr_uf", {7'd0, rerr_uf}, {7'd0, it.uf});
        if (it.onebit) chk("rptr_one_bit_change", 8'($countones(rptr ^ prev_ptr)), 8'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   guard;
    rrst_n = 1'b0; rinc = 1'b0; rclr_err = 1'b0; rq2_wptr = '0;

    // Reset
    step(0, 0, 0, 4'd0, mk(1'bx, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, 4'd0, mk(0, 1, 1, 0, 0, 0, 0));

    // One word in, one word out
    step(1, 0, 0, 4'b0001, mk(0, 0, 1, 1, 4'b0000, 0, 0));
    step(1, 1, 0, 4'b0001, mk(1, 1, 1, 0, 4'b0001, 1, 0));

    // Fill to 8 words then drain through the almost-empty threshold
    step(1, 0, 0, g(9), mk(0, 0, 0, 8, g(1), 1, 0));
    for (int k = 1; k <= 8; k++)
      step(1, 1, 0, g(9), mk(1, k == 8, (8 - k) <= 2, 4'(8 - k), g(1 + k), 3'((1 + k) & 7), 0));

    // Streaming read/write across the pointer wrap, level held at 1
    step(1, 0, 0, g(10), mk(0, 0, 1, 1, g(9), 1, 0));
    for (int i = 1; i <= 20; i++) begin
      e = mk(1, 0, 1, 1, g(9 + i), 3'((9 + i) & 7), 0);
      e.onebit = 1'b1;
      step(1, 1, 0, g(10 + i), e);
    end
    e = mk(1, 1, 1, 0, g(30), 3'd6, 0);
    e.onebit = 1'b1;
    step(1, 1, 0, g(30), e);

    // Underflow, clear, and set-beats-clear
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, g(30), mk(0, 1, 1, 0, g(14), 6, 1));
    step(1, 0, 1, g(30), mk(0, 1, 1, 0, g(14), 6, 0));
    step(1, 1, 1, g(30), mk(0, 1, 1, 0, g(14), 6, 1));
    step(1, 0, 1, g(30), mk(0, 1, 1, 0, g(14), 6, 0));

    // Build rbin=9 / level=5, then reset mid-stream
    step(0, 0, 0, 4'd0, mk(0, 1, 1, 0, 0, 0, 0));
    step(1, 0, 0, g(8), mk(0, 0, 0, 8, 0, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      int wb;
      int lvl;
      wb  = (k <= 3) ? 8 : k + 5;
      lvl = wb - k;
      step(1, 1, 0, g(wb), mk(1, 0, lvl <= 2, 4'(lvl), g(k), 3'(k & 7), 0));
    end
    e = mk(1, 1, 1, 0, 0, 0, 0);
    e.chk_pre = 1'b1;
    e.pre_lvl = 4'd5;
    step(0, 1, 0, g(14), e);
    step(1, 0, 0, 4'd0, mk(0, 1, 1, 0, 0, 0, 0));

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge rclk);
      guard++;
    end
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
    end
    @(negedge rclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
